// File: rtl/stream_vector_feeder_if.sv
// Valid/ready stream carrying signed words from the feeder (master) to the network input (slave).
interface stream_vector_feeder_if #(
  parameter int WIDTH = 16
) ();
  logic signed [WIDTH-1:0] m_data_out_x;
  logic                    m_valid_x;
  logic                    m_ready_x;

  modport master (
    output m_data_out_x,
    output m_valid_x,
    input  m_ready_x
  );

  modport slave (
    input  m_data_out_x,
    input  m_valid_x,
    output m_ready_x
  );
endinterface

// File: rtl/stream_vector_feeder.sv
// Streams a host-preloaded DEPTH-word vector REPS times; FEEDER_CHECKSUM_EN adds a running sum of emitted words.
// First valid one cycle after start; data held under backpressure, one word per cycle while ready stays high.
module stream_vector_feeder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [15:0]             reps,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  stream_vector_feeder_if.master  m_if,
  output logic [31:0]             checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0]           r_idx;
  logic [15:0]             r_rep;
  logic [15:0]             r_reps;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;
  logic                    r_busy;
  logic                    r_done;

  logic [AW-1:0]           w_idx_nxt;
  logic [15:0]             w_rep_nxt;
  logic [15:0]             w_reps_nxt;
  logic signed [WIDTH-1:0] w_data_nxt;
  logic                    w_valid_nxt;
  logic                    w_busy_nxt;
  logic                    w_done_nxt;

  logic                    w_wr_ok;
  logic                    w_hs;
  logic                    w_start_ok;
  logic                    w_last_idx;
  logic                    w_last_rep;
  logic [AW-1:0]           w_idx_inc;
  logic signed [WIDTH-1:0] w_word0;

  assign w_wr_ok    = wr_en && (r_state == S_IDLE) && (int'({1'b0, wr_addr}) < DEPTH);
  assign w_hs       = r_valid && m_if.m_ready_x;
  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_last_idx = (r_idx == AW'(DEPTH - 1));
  assign w_last_rep = (r_rep == (r_reps - 16'd1));
  assign w_idx_inc  = w_last_idx ? '0 : (r_idx + 1'b1);

  // A write landing on the same edge as start must already be visible in word 0.
  assign w_word0 = (w_wr_ok && (wr_addr == '0)) ? wr_data : r_mem[0];

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rep_nxt   = r_rep;
    w_reps_nxt  = r_reps;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (reps != 16'd0) begin
            w_state_nxt = S_STREAM;
            w_reps_nxt  = reps;
            w_idx_nxt   = '0;
            w_rep_nxt   = 16'd0;
            w_busy_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_data_nxt  = w_word0;
          end else begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (w_hs) begin
          w_idx_nxt  = w_idx_inc;
          w_data_nxt = r_mem[w_idx_inc];
          if (w_last_idx) begin
            if (w_last_rep) begin
              w_state_nxt = S_DONE;
              w_valid_nxt = 1'b0;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
              w_data_nxt  = r_data;
            end else begin
              w_rep_nxt = r_rep + 16'd1;
            end
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rep   <= 16'd0;
      r_reps  <= 16'd0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rep   <= w_rep_nxt;
      r_reps  <= w_reps_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign m_if.m_data_out_x = r_data;
  assign m_if.m_valid_x    = r_valid;
  assign busy              = r_busy;
  assign done              = r_done;

`ifdef FEEDER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_checksum <= 32'd0;
    end else if (w_start_ok) begin
      r_checksum <= 32'd0;
    end else if (w_hs) begin
      r_checksum <= r_checksum + {{(32-WIDTH){r_data[WIDTH-1]}}, r_data};
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

endmodule
